// File: rtl/peripheral_mult_seq.sv
// Memory-mapped sequential multiplier peripheral.
// Radix-2 shift-add engine, one multiplier bit per cycle, signed/unsigned,
// 2*WIDTH-bit product readable as two 32-bit words, done/busy/err status
// and a maskable level interrupt.
module peripheral_mult_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  output logic        irq
);

  localparam logic [4:0] ADDR_A      = 5'h04;
  localparam logic [4:0] ADDR_B      = 5'h08;
  localparam logic [4:0] ADDR_CTRL   = 5'h0C;
  localparam logic [4:0] ADDR_RES_LO = 5'h10;
  localparam logic [4:0] ADDR_RES_HI = 5'h14;
  localparam logic [4:0] ADDR_STATUS = 5'h18;
  localparam logic [4:0] ADDR_IE     = 5'h1C;
  localparam int unsigned CNT_W      = 6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     a_reg, b_reg;
  logic                 sgn, ie, done, err, busy;
  logic [2*WIDTH-1:0]   product;
  logic [2*WIDTH-1:0]   mcand, acc, acc_sum;
  logic [WIDTH-1:0]     mplier, mag_a, mag_b;
  logic [CNT_W-1:0]     cnt;
  logic                 res_neg;
  logic                 wr_en, rd_en, start_req, start_ok, last_step;
  logic                 status_wr;
  logic [63:0]          prod_ext;
  logic [31:0]          rd_mux;

  assign wr_en     = cs & wr;
  assign rd_en     = cs & rd;
  assign start_req = wr_en && (addr == ADDR_CTRL) && d_in[0];
  assign start_ok  = start_req && (state == IDLE);
  assign last_step = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign status_wr = wr_en && (addr == ADDR_STATUS);

  // Sign mode for the new operation comes from the same CTRL write as start.
  assign mag_a   = (d_in[1] && a_reg[WIDTH-1]) ? -a_reg : a_reg;
  assign mag_b   = (d_in[1] && b_reg[WIDTH-1]) ? -b_reg : b_reg;
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  assign prod_ext = 64'(product);
  assign irq      = done & ie;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)  state_nxt = RUN;
      RUN:     if (last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-add engine: latch magnitudes on start, then one bit per cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      res_neg <= 1'b0;
    end else if (start_ok) begin
      mcand   <= {{WIDTH{1'b0}}, mag_a};
      mplier  <= mag_b;
      acc     <= '0;
      cnt     <= '0;
      res_neg <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) & d_in[1];
    end else if (state == RUN) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Programmer-visible registers, status flags and product capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sgn     <= 1'b0;
      ie      <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      product <= '0;
    end else begin
      if (wr_en) begin
        case (addr)
          ADDR_A:    a_reg <= d_in[WIDTH-1:0];
          ADDR_B:    b_reg <= d_in[WIDTH-1:0];
          ADDR_CTRL: sgn   <= d_in[1];
          ADDR_IE:   ie    <= d_in[0];
          default:   ;
        endcase
      end
      if (start_ok)       busy <= 1'b1;
      else if (last_step) busy <= 1'b0;
      // Completion outranks a coincident done clear; start outranks both.
      if (start_ok)                   done <= 1'b0;
      else if (last_step)             done <= 1'b1;
      else if (status_wr && d_in[0])  done <= 1'b0;
      if (start_req && state == RUN)  err <= 1'b1;
      else if (status_wr && d_in[2])  err <= 1'b0;
      if (last_step) product <= res_neg ? -acc_sum : acc_sum;
    end
  end

  // Read data select
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_A:      rd_mux = 32'(a_reg);
      ADDR_B:      rd_mux = 32'(b_reg);
      ADDR_CTRL:   rd_mux = {30'd0, sgn, 1'b0};
      ADDR_RES_LO: rd_mux = prod_ext[31:0];
      ADDR_RES_HI: rd_mux = prod_ext[63:32];
      ADDR_STATUS: rd_mux = {29'd0, err, busy, done};
      ADDR_IE:     rd_mux = {31'd0, ie};
      default:     rd_mux = '0;
    endcase
  end

  // Registered read port, holds between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     d_out <= '0;
    else if (rd_en) d_out <= rd_mux;
  end

endmodule

// File: doc/peripheral_mult_seq.md
Name: peripheral_mult_seq

Overview:
Parametrised memory-mapped multiplier peripheral: a successor to the fixed 16x16 multiplier peripheral on the CPU I/O bus.
- Operand width is generic; signed and unsigned modes supported.
- Internal radix-2 shift-add engine computes one operand bit per cycle.
- Full 2*WIDTH product is readable as two 32-bit words.
- Adds busy/error status, write-1-to-clear done, and a maskable interrupt.

Parameters:
WIDTH, 16, operand width in bits; legal range 2..32; product is 2*WIDTH bits.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
d_in  input  32  write data; only bits [WIDTH-1:0] are used for operands
cs  input  1  peripheral chip select
addr  input  5  register address (byte offset)
rd  input  1  read strobe
wr  input  1  write strobe
d_out  output  32  registered read data
irq  output  1  interrupt request, level, = done & ie

Behaviour:
Register map (decoded only when cs=1; writes need cs&wr):
- 0x04 A (RW): operand A[WIDTH-1:0].
- 0x08 B (RW): operand B[WIDTH-1:0].
- 0x0C CTRL (W): bit0 start (self-clearing pulse, not stored); bit1 sgn (stored, read back on bit1).
- 0x10 RES_LO (R): product[31:0].
- 0x14 RES_HI (R): product[2*WIDTH-1:32]; zero-extended; reads 0 when WIDTH<=16.
- 0x18 STATUS: bit0 done, bit1 busy, bit2 err. Write: bit0=1 clears done, bit2=1 clears err.
- 0x1C IE (RW): bit0 interrupt enable.
- Unmapped address reads 0; writes to it are ignored.

Reset (reset=0, asynchronous): all of the following are 0 — A, B, sgn, ie, done, err, busy, product, d_out, irq. FSM goes to IDLE.

Read path:
- d_out loads the selected register at the posedge where cs&rd=1.
- Read latency is one cycle.
- d_out holds its value otherwise.

FSM: IDLE, RUN.
- IDLE -> RUN on the edge with cs&wr at CTRL and d_in[0]=1 (edge T). On that edge:
  - latch the sign mode from d_in[1];
  - latch the magnitudes of A and B;
  - latch the result sign: (A[W-1]^B[W-1]) & sgn;
  - clear the accumulator and the iteration counter;
  - done<=0; busy<=1.
- RUN: each edge adds the shifted multiplicand when the current multiplier bit is 1, and increments the counter.
- On edge T+WIDTH: product <= accumulator, two's-complement negated if the result sign is set; done<=1; busy<=0; FSM -> IDLE.
- Result is readable from T+WIDTH+1 (issue rd that cycle; data arrives one cycle later).

Arithmetic:
- Magnitudes are WIDTH-bit unsigned. The most-negative operand has magnitude 2^(WIDTH-1); no overflow is possible.
- Unsigned mode ignores operand signs.

Boundary rules:
- Start while busy: ignored; the current operation is unaffected; err<=1 (sticky).
- Writes to A, B or the sgn bit while busy: registers update; the running operation uses its latched copies.
- Result registers keep their old value until the edge where the new result completes.
- Clear of done coincident with completion: completion wins, done=1.
- Start coincident with a done clear: start wins, done=0.
- Reset mid-RUN: immediate abort; all state returns to reset values.
- irq follows done&ie combinationally from registers and deasserts on done clear or ie=0.

Test Plan:
- WIDTH=16, unsigned, A=0xFFFF, B=0xFFFF, start -> busy=1 for 16 cycles; done=1 at T+16; RES_LO=0xFFFE0001; RES_HI=0.
- WIDTH=16, signed, A=0xFFFD (-3), B=0x0005, start -> RES_LO=0xFFFFFFF1; same operands unsigned -> RES_LO=0x0004FFF1.
- WIDTH=32, unsigned, A=0xFFFFFFFF, B=2 -> RES_HI=0x00000001, RES_LO=0xFFFFFFFE. Signed A=0x80000000, B=0x80000000 -> RES_HI=0x40000000, RES_LO=0.
- Start at T, second start at T+3, B rewritten at T+4 -> err=1; result matches first operands; STATUS write 0x4 -> err=0.
- ie=1, operation completes -> irq=1 at T+16; STATUS write 0x1 -> done=0 and irq=0 next cycle.
- reset pulsed low mid-RUN at T+5 -> busy, done, product, d_out and irq are 0 immediately; a new start then completes normally.
